// File: rtl/lerp_seq.sv
// lerp_seq: time-multiplexed RGB blend through one shared MAC pipeline (define LERP_SEQ_DIV255_EN for exact /255 scaling)
module lerp_seq #(
    parameter bit BGR = 1'b1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] c0,
    input  logic [23:0] c1,
    input  logic [7:0]  t,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] rgb24
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;
    state_t      state, state_d;
    logic [1:0]  ch, ch_d;
    logic        load, issue, capture;
    logic [23:0] c0_q, c1_q;
    logic [7:0]  t_q;
    logic [7:0]  op_t, op_a, op_nt, op_b;
    logic [15:0] p0, p1, sum;
    logic [7:0]  m, red, grn, blu;
`ifdef LERP_SEQ_DIV255_EN
    logic [15:0] rnd;
    assign rnd = sum + 16'd1 + {8'd0, sum[15:8]};
    assign m   = rnd[15:8];
`else
    assign m   = sum[15:8];
`endif
    assign in_ready  = state == IDLE;
    assign out_valid = state == HOLD;
    assign rgb24     = BGR ? {blu, grn, red} : {red, grn, blu};
    // state and channel counter
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            state <= IDLE;
            ch    <= 2'd0;
        end else begin
            state <= state_d;
            ch    <= ch_d;
        end
    // next state: ch walks 0..2 while issuing, then again while draining results
    always_comb begin
        state_d = state;
        ch_d    = ch;
        load    = 1'b0;
        issue   = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: if (in_valid) begin
                load    = 1'b1;
                ch_d    = 2'd0;
                state_d = ISSUE;
            end
            ISSUE: begin
                issue   = 1'b1;
                ch_d    = ch == 2'd2 ? 2'd0 : ch + 2'd1;
                state_d = ch == 2'd2 ? DRAIN : ISSUE;
            end
            DRAIN: begin
                capture = 1'b1;
                ch_d    = ch == 2'd2 ? 2'd0 : ch + 2'd1;
                state_d = ch == 2'd2 ? HOLD : DRAIN;
            end
            default: state_d = out_ready ? IDLE : HOLD;
        endcase
    end
    // request holding registers so the source may move on after the transfer
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            c0_q <= '0;
            c1_q <= '0;
            t_q  <= '0;
        end else if (load) begin
            c0_q <= c0;
            c1_q <= c1;
            t_q  <= t;
        end
    // S1: operands of the channel selected by ch
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            op_t  <= '0;
            op_a  <= '0;
            op_nt <= '0;
            op_b  <= '0;
        end else if (issue) begin
            op_t  <= t_q;
            op_nt <= 8'd255 - t_q;
            op_a  <= ch == 2'd0 ? c0_q[23:16] : ch == 2'd1 ? c0_q[15:8] : c0_q[7:0];
            op_b  <= ch == 2'd0 ? c1_q[23:16] : ch == 2'd1 ? c1_q[15:8] : c1_q[7:0];
        end
    // S2 products and S3 sum advance every cycle; DRAIN timing picks the right slot
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            p0  <= '0;
            p1  <= '0;
            sum <= '0;
        end else begin
            p0  <= 16'(op_t) * 16'(op_a);
            p1  <= 16'(op_nt) * 16'(op_b);
            sum <= p0 + p1;
        end
    // result registers, one channel captured per DRAIN cycle
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            red <= '0;
            grn <= '0;
            blu <= '0;
        end else if (capture) begin
            red <= ch == 2'd0 ? m : red;
            grn <= ch == 2'd1 ? m : grn;
            blu <= ch == 2'd2 ? m : blu;
        end
endmodule

// File: doc/lerp_seq.md
# lerp_seq

Time-multiplexed colour interpolator: it accepts one pixel request (two 24-bit endpoint colours plus an 8-bit blend factor) and runs all three channels through a single shared multiply-accumulate pipeline. The result is returned as one packed 24-bit colour. It replaces three parallel per-channel blenders in the pixel painters, trading throughput for LUT/DSP area. It sits between the frame/pixel scanner and the PWM/gamma LED output stage.

## Interface
- `BGR`, default 1: output packing. 1 packs `{blu,grn,red}`; 0 packs `{red,grn,blu}`.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request.
- `c0`  in  24  endpoint A, `{red[23:16], grn[15:8], blu[7:0]}`.
- `c1`  in  24  endpoint B, same layout.
- `t`  in  8  blend factor; weight of `c0`.
- `out_valid`  out  1  `rgb24` holds a result.
- `out_ready`  in  1  consumer takes the result.
- `rgb24`  out  24  blended colour, packed per `BGR`.

## Operation
- Per channel: `x = t*a + (255-t)*b`, where `a` is the `c0` channel and `b` is the `c1` channel.
  - `x` is a 16-bit unsigned value; it cannot overflow, since the maximum is 65025.
  - `m = x[15:8]`, unless the configuration macro is defined (see Configuration).
- Shared pipeline has three register stages:
  - S1: operand registers `t`, `a`, `255-t`, `b`.
  - S2: two 16-bit products.
  - S3: 16-bit sum.
  - `m` is combinational from S3.
- The request is a transfer when `in_valid && in_ready` at a rising edge. On a transfer, `c0`, `c1` and `t` are latched into holding registers. Inputs may change afterwards.
- FSM states:
  - IDLE: `in_ready=1`. A transfer moves to ISSUE with channel counter `ch=0`.
  - ISSUE: present channel `ch` (0=red, 1=grn, 2=blu) to S1 on each edge, then increment `ch`. After `ch=2`, go to DRAIN.
  - DRAIN: capture `m` into the red, grn and blu result registers as each channel exits S3. After blu is captured, go to HOLD.
  - HOLD: `out_valid=1` and `rgb24` is stable. When `out_ready=1` at an edge, go to IDLE.
- `in_ready` is 1 only in IDLE. There is no request overlap; one pixel is in flight at a time.
- `out_ready` is ignored outside HOLD.
- `in_valid` is ignored outside IDLE. A request that is presented but not accepted must be held by the source.
- `t=0` selects pure `c1` (scaled); `t=255` selects pure `c0` (scaled). There are no clamp or saturation paths.

## Timing
- Let E0 be the acceptance edge.
- S1 latches channel operands: red at E1, grn at E2, blu at E3.
- Results are captured from S3: red at E4, grn at E5, blu at E6.
- `out_valid` rises after E6. Latency is 6 edges from accept to `out_valid`.
- If `out_ready` is already high, HOLD exits at E7 and `in_ready` is high after E7. The next request can be accepted at E8 at the earliest, giving 8 cycles per pixel.
- Reset, while `resetn=0`, asynchronously forces:
  - state IDLE, `ch=0`;
  - all pipeline, holding and result registers 0;
  - `out_valid=0`, `rgb24=0`, `in_ready=1`.
- Transfers seen while `resetn=0` are discarded.
- Reset asserted mid-operation aborts the pixel. No partial result is ever presented.
- Deassertion is treated as synchronous by the caller. The block accepts a request at the first edge with `resetn=1`.

## Configuration
- `LERP_SEQ_DIV255_EN` defined: `m = (x + 1 + x[15:8]) >> 8`. This is an exact `x/255` for 0 ≤ x ≤ 65025, so `t=255` reproduces `c0` exactly. It costs one 16-bit adder in S3 output logic; latency is unchanged.
- `LERP_SEQ_DIV255_EN` undefined: `m = x[15:8]`, a divide by 256. Results are at most 1 LSB low.

## Test plan
- Reset values: hold `resetn=0` with random inputs and `in_valid=1` -> `out_valid=0`, `rgb24=0`, `in_ready=1`. Release, then accept.
- Basic blend: `c0=24'h360033`, `c1=24'h0b8793`, `t=0`, `out_ready=1`, `BGR=1`.
  - Required: `rgb24=24'h92860a` (undefined macro) or `24'h93870b` (defined).
  - Required: `out_valid` rises exactly 6 edges after acceptance.
- Other endpoint: same colours, `t=255` -> `24'h320035` (undefined) or `24'h330036` (defined). With `BGR=0`, the undefined case gives `24'h350032`.
- Backpressure: `out_ready=0` for 10 cycles after `out_valid` rises.
  - Required: `rgb24` stable, `in_ready=0`, and a second request held on `in_valid` is not accepted.
  - After `out_ready` pulses for one edge: `out_valid=0`, then the held request is accepted.
- Reset mid-operation: assert `resetn=0` between E2 and E5, release, then issue `c0=24'hffffff`, `c1=0`, `t=255`.
  - Required: a single result appears, `24'hfefefe` (undefined) or `24'hffffff` (defined).
  - Required: no stale pixel appears.
- Back-to-back stream: 100 random requests with random `out_ready` stalls -> every result matches the reference formula. Exactly one output per accepted input, in order.
